sd_block_reader: RTL and testbench

- Single-block read engine for the SD SPI path; sits directly downstream of the SD initialisation sequencer and takes over the SD pins once init asserts isFinish.
- On each request it issues CMD17 for one 512-byte block and waits for R1 and the start token.
- Streams the 512 payload bytes out one byte at a time with a valid strobe, discards the CRC, then releases the bus.
- Self-contained: owns its SPI clock divider and shifter; no shared command submodule.

---
 rtl/sd_block_reader_if.sv | 29 ++
 rtl/sd_block_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_reader_if.sv
// Pin and request/response bundle of the SD single-block reader.
// slave is the reader itself; master is the host plus card side.
interface sd_block_reader_if;
   logic        isStart;
   logic [31:0] blockAddr;
   logic        isBusy;
   logic        isFinish;
   logic        error;
   logic [1:0]  errorCode;
   logic [7:0]  dataOut;
   logic        dataValid;
   logic [8:0]  byteIndex;
   logic        SCLK;
   logic        DI;
   logic        CS;
   logic        DO;

   modport slave (
      input  isStart, blockAddr, DO,
      output isBusy, isFinish, error, errorCode, dataOut, dataValid, byteIndex,
             SCLK, DI, CS
   );

   modport master (
      output isStart, blockAddr, DO,
      input  isBusy, isFinish, error, errorCode, dataOut, dataValid, byteIndex,
             SCLK, DI, CS
   );
endinterface

// File: rtl/sd_block_reader.sv
// SD SPI single-block reader: issues CMD17, waits for R1 and the start token,
// streams 512 payload bytes with a strobe, drops the CRC and releases the bus.
module sd_block_reader #(
   parameter int CLK_DIV       = 100,
   parameter int R1_TIMEOUT    = 8,
   parameter int TOKEN_TIMEOUT = 4096
) (
   input logic clk,
   input logic reset,
   sd_block_reader_if.slave bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = ($clog2(TOKEN_TIMEOUT + 1) > 10) ? $clog2(TOKEN_TIMEOUT + 1) : 10;

   typedef enum logic [3:0] {IDLE, PRE, CMD, R1, TOKEN, DATA, CRC, TAIL, DONE} state_t;

   state_t           state;
   logic [DIV_W-1:0] divCnt;
   logic             sclkReg;
   logic             csReg;
   logic             diReg;
   logic [7:0]       txShift;
   logic [6:0]       rxShift;
   logic [2:0]       bitCnt;
   logic [CNT_W-1:0] byteCnt;
   logic [47:0]      cmdFrame;
   logic             tailEnd;
   logic             isBusyReg;
   logic             isFinishReg;
   logic             errorReg;
   logic [1:0]       errorCodeReg;
   logic [7:0]       dataOutReg;
   logic             dataValidReg;
   logic [8:0]       byteIndexReg;

   logic       active;
   logic       divTick;
   logic       riseTick;
   logic       fallTick;
   logic       byteDone;
   logic [7:0] rxByte;

   assign active   = (state != IDLE) && (state != DONE);
   assign divTick  = active && (divCnt == DIV_W'(CLK_DIV - 1));
   assign riseTick = divTick && !sclkReg;
   assign fallTick = divTick && sclkReg;
   // A byte is complete on its 8th rising edge; the received byte includes the bit sampled now.
   assign byteDone = riseTick && (bitCnt == 3'd7);
   assign rxByte   = {rxShift, bus.DO};

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         divCnt       <= '0;
         sclkReg      <= 1'b0;
         csReg        <= 1'b1;
         diReg        <= 1'b1;
         txShift      <= 8'hFF;
         rxShift      <= '0;
         bitCnt       <= '0;
         byteCnt      <= '0;
         cmdFrame     <= '0;
         tailEnd      <= 1'b0;
         isBusyReg    <= 1'b0;
         isFinishReg  <= 1'b0;
         errorReg     <= 1'b0;
         errorCodeReg <= 2'd0;
         dataOutReg   <= 8'd0;
         dataValidReg <= 1'b0;
         byteIndexReg <= 9'd0;
      end else begin
         dataValidReg <= 1'b0;

         if (divTick) begin
            divCnt  <= '0;
            sclkReg <= ~sclkReg;
         end else if (active) begin
            divCnt <= divCnt + DIV_W'(1);
         end else begin
            divCnt  <= '0;
            sclkReg <= 1'b0;
         end

         // The next byte is staged into txShift at byteDone; its MSB leaves on the following fall.
         if (fallTick) begin
            diReg   <= txShift[7];
            txShift <= {txShift[6:0], 1'b1};
         end
         if (riseTick) begin
            rxShift <= rxByte[6:0];
            bitCnt  <= bitCnt + 3'd1;
         end

         unique case (state)
            IDLE: begin
               csReg <= 1'b1;
               diReg <= 1'b1;
               if (bus.isStart) begin
                  state        <= PRE;
                  csReg        <= 1'b0;
                  cmdFrame     <= {8'h51, bus.blockAddr, 8'hFF};
                  txShift      <= 8'hFF;
                  bitCnt       <= '0;
                  byteCnt      <= '0;
                  tailEnd      <= 1'b0;
                  isBusyReg    <= 1'b1;
                  errorReg     <= 1'b0;
                  errorCodeReg <= 2'd0;
               end
            end
            PRE: begin
               if (byteDone) begin
                  txShift  <= cmdFrame[47:40];
                  cmdFrame <= {cmdFrame[39:0], 8'h00};
                  byteCnt  <= '0;
                  state    <= CMD;
               end
            end
            CMD: begin
               if (byteDone) begin
                  if (byteCnt == CNT_W'(5)) begin
                     txShift <= 8'hFF;
                     byteCnt <= '0;
                     state   <= R1;
                  end else begin
                     txShift  <= cmdFrame[47:40];
                     cmdFrame <= {cmdFrame[39:0], 8'h00};
                     byteCnt  <= byteCnt + CNT_W'(1);
                  end
               end
            end
            R1: begin
               if (byteDone) begin
                  if (!rxByte[7]) begin
                     if (rxByte == 8'h00) begin
                        byteCnt <= '0;
                        state   <= TOKEN;
                     end else begin
                        errorReg     <= 1'b1;
                        errorCodeReg <= 2'd2;
                        state        <= TAIL;
                     end
                  end else if (byteCnt == CNT_W'(R1_TIMEOUT - 1)) begin
                     errorReg     <= 1'b1;
                     errorCodeReg <= 2'd1;
                     state        <= TAIL;
                  end else begin
                     byteCnt <= byteCnt + CNT_W'(1);
                  end
               end
            end
            TOKEN: begin
               if (byteDone) begin
                  if (rxByte == 8'hFE) begin
                     byteCnt <= '0;
                     state   <= DATA;
                  end else if (rxByte[7:4] == 4'h0) begin
                     errorReg     <= 1'b1;
                     errorCodeReg <= 2'd3;
                     state        <= TAIL;
                  end else if (byteCnt == CNT_W'(TOKEN_TIMEOUT - 1)) begin
                     errorReg     <= 1'b1;
                     errorCodeReg <= 2'd1;
                     state        <= TAIL;
                  end else begin
                     byteCnt <= byteCnt + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (byteDone) begin
                  dataOutReg   <= rxByte;
                  byteIndexReg <= byteCnt[8:0];
                  dataValidReg <= 1'b1;
                  if (byteCnt == CNT_W'(511)) begin
                     byteCnt <= '0;
                     state   <= CRC;
                  end else begin
                     byteCnt <= byteCnt + CNT_W'(1);
                  end
               end
            end
            CRC: begin
               if (byteDone) begin
                  if (byteCnt == CNT_W'(1)) begin
                     state <= TAIL;
                  end else begin
                     byteCnt <= byteCnt + CNT_W'(1);
                  end
               end
            end
            TAIL: begin
               // Finish on the falling edge that closes the 8th tail clock, so SCLK ends low.
               if (byteDone) begin
                  tailEnd <= 1'b1;
               end
               if (fallTick && tailEnd) begin
                  state       <= DONE;
                  csReg       <= 1'b1;
                  tailEnd     <= 1'b0;
                  isBusyReg   <= 1'b0;
                  isFinishReg <= 1'b1;
               end
            end
            DONE: begin
               csReg <= 1'b1;
               if (!bus.isStart) begin
                  isFinishReg <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.SCLK      = sclkReg;
   assign bus.CS        = csReg;
   assign bus.DI        = diReg;
   assign bus.isBusy    = isBusyReg;
   assign bus.isFinish  = isFinishReg;
   assign bus.error     = errorReg;
   assign bus.errorCode = errorCodeReg;
   assign bus.dataOut   = dataOutReg;
   assign bus.dataValid = dataValidReg;
   assign bus.byteIndex = byteIndexReg;

endmodule

// File: tb/tb_sd_block_reader.sv
// Randomized bench for sd_block_reader: byte-level SD card model, strobe
// scoreboard and an outcome model derived from the card script.
module tb_sd_block_reader;

   localparam int CLK_DIV = 2;
   localparam int R1_TO   = 8;
   localparam int TOK_TO  = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sd_block_reader_if bus();

   sd_block_reader #(
      .CLK_DIV(CLK_DIV),
      .R1_TIMEOUT(R1_TO),
      .TOKEN_TIMEOUT(TOK_TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] idx;
      logic [7:0] data;
   } strobe_t;

   strobe_t    expQ[$];
   logic [7:0] misoQ[$];
   logic [7:0] mosiLog[$];
   int checks = 0;
   int fails = 0;
   int strobeCnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Card model: byte stream from misoQ after CS falls, MOSI bytes logged.
   logic       prevCs = 1'b1;
   logic       prevSclk = 1'b0;
   logic [7:0] cur = 8'hFF;
   logic [7:0] mosiSh = 8'h00;
   int         bitPos = 7;
   int         nBits = 0;
   bit         byteEnd = 1'b0;

   function automatic logic [7:0] nextMiso();
      if (misoQ.size() > 0) return misoQ.pop_front();
      return 8'hFF;
   endfunction

   always @(bus.CS or bus.SCLK) begin
      if (prevCs && !bus.CS) begin
         cur = nextMiso();
         bitPos = 7;
         nBits = 0;
         byteEnd = 1'b0;
         bus.DO = cur[7];
      end else if (!bus.CS && !prevSclk && bus.SCLK) begin
         mosiSh = {mosiSh[6:0], bus.DI};
         nBits++;
         if (nBits == 8) begin
            mosiLog.push_back(mosiSh);
            nBits = 0;
            byteEnd = 1'b1;
         end
      end else if (!bus.CS && prevSclk && !bus.SCLK) begin
         if (byteEnd) begin
            cur = nextMiso();
            bitPos = 7;
            byteEnd = 1'b0;
         end else begin
            bitPos--;
         end
         bus.DO = cur[bitPos];
      end
      prevCs = bus.CS;
      prevSclk = bus.SCLK;
   end

   // Strobe monitor
   always @(negedge clk) begin
      strobe_t e;
      if (bus.dataValid) begin
         strobeCnt++;
         if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_strobe: got index %0d data 0x%0h, required no strobe",
                     bus.byteIndex, bus.dataOut);
         end else begin
            e = expQ.pop_front();
            check("strobe_index", 32'(bus.byteIndex), 32'(e.idx));
            check("strobe_data", 32'(bus.dataOut), 32'(e.data));
         end
      end
   end

   task automatic checkReset(input string tag);
      check({tag, "_cs"}, 32'(bus.CS), 32'(1));
      check({tag, "_di"}, 32'(bus.DI), 32'(1));
      check({tag, "_sclk"}, 32'(bus.SCLK), 32'(0));
      check({tag, "_busy"}, 32'(bus.isBusy), 32'(0));
      check({tag, "_finish"}, 32'(bus.isFinish), 32'(0));
      check({tag, "_error"}, 32'(bus.error), 32'(0));
      check({tag, "_code"}, 32'(bus.errorCode), 32'(0));
      check({tag, "_valid"}, 32'(bus.dataValid), 32'(0));
      check({tag, "_data"}, 32'(bus.dataOut), 32'(0));
      check({tag, "_index"}, 32'(bus.byteIndex), 32'(0));
   endtask

   task automatic runRead(input logic [31:0] addr, input int r1Delay, input logic [7:0] r1,
                          input int tokDelay, input logic [7:0] tok, input bit nominal,
                          input int holdClks);
      int code, nBytes, cyc, bad;
      bit dataPhase, stayed;
      logic [7:0] p, v, act;
      logic [7:0] hdr [7];
      strobe_t e;
      misoQ.delete();
      mosiLog.delete();
      expQ.delete();

      // Reference model of the outcome from the card script
      code = 0;
      nBytes = 7;
      dataPhase = 1'b0;
      if (r1Delay >= R1_TO) begin
         code = 1;
         nBytes += R1_TO;
      end else begin
         nBytes += r1Delay + 1;
         if (r1 != 8'h00) code = 2;
         else if (tokDelay >= TOK_TO) begin
            code = 1;
            nBytes += TOK_TO;
         end else begin
            nBytes += tokDelay + 1;
            if (tok == 8'hFE) begin
               dataPhase = 1'b1;
               nBytes += 514;
            end else begin
               code = 3;
            end
         end
      end
      nBytes += 1;

      repeat (7) misoQ.push_back(8'hFF);
      for (int i = 0; i < r1Delay; i++) begin
         v = nominal ? 8'hFF : 8'($urandom_range(128, 255));
         misoQ.push_back(v);
      end
      misoQ.push_back(r1);
      for (int i = 0; i < tokDelay; i++) begin
         v = nominal ? 8'hFF : 8'($urandom_range(16, 255));
         if (v == 8'hFE) v = 8'hFF;
         misoQ.push_back(v);
      end
      misoQ.push_back(tok);
      for (int i = 0; i < 512; i++) begin
         p = nominal ? 8'(i) : 8'($urandom);
         misoQ.push_back(p);
         if (dataPhase) begin
            e.idx = 9'(i);
            e.data = p;
            expQ.push_back(e);
         end
      end
      misoQ.push_back(8'hAB);
      misoQ.push_back(8'hCD);

      @(negedge clk);
      bus.blockAddr = addr;
      bus.isStart = 1'b1;
      @(negedge clk);
      check("busy_on_accept", 32'(bus.isBusy), 32'(1));
      check("cs_low_on_accept", 32'(bus.CS), 32'(0));
      bus.blockAddr = ~addr;
      cyc = 0;
      while (!bus.isFinish && cyc < 40000) begin
         @(negedge clk);
         cyc++;
      end
      check("finish", 32'(bus.isFinish), 32'(1));
      check("transfer_clks", 32'(cyc), 32'(16 * nBytes * CLK_DIV));
      check("busy_done", 32'(bus.isBusy), 32'(0));
      check("error", 32'(bus.error), 32'(code != 0));
      check("error_code", 32'(bus.errorCode), 32'(code));
      check("cs_released", 32'(bus.CS), 32'(1));
      check("sclk_idle", 32'(bus.SCLK), 32'(0));
      check("mosi_bytes", 32'(mosiLog.size()), 32'(nBytes));
      hdr = '{8'hFF, 8'h51, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 8'hFF};
      for (int i = 0; i < 7; i++) begin
         act = (i < mosiLog.size()) ? mosiLog[i] : 8'h00;
         check($sformatf("mosi_hdr%0d", i), 32'(act), 32'(hdr[i]));
      end
      bad = 0;
      for (int i = 7; i < mosiLog.size(); i++) if (mosiLog[i] != 8'hFF) bad++;
      check("mosi_idle_ff", 32'(bad), 32'(0));
      check("strobes_left", 32'(expQ.size()), 32'(0));

      stayed = 1'b1;
      repeat (holdClks) begin
         @(negedge clk);
         if (!bus.isFinish) stayed = 1'b0;
      end
      check("finish_held", 32'(stayed), 32'(1));
      check("no_retrigger", 32'(mosiLog.size()), 32'(nBytes));
      bus.isStart = 1'b0;
      @(negedge clk);
      check("finish_drop", 32'(bus.isFinish), 32'(0));
      $display("read addr=%08h r1Delay=%0d r1=%02h tokDelay=%0d tok=%02h code=%0d bytes=%0d clks=%0d",
               addr, r1Delay, r1, tokDelay, tok, code, nBytes, cyc);
   endtask

   task automatic resetMidData();
      int base, cyc;
      logic [7:0] p;
      strobe_t e;
      misoQ.delete();
      mosiLog.delete();
      expQ.delete();
      repeat (7) misoQ.push_back(8'hFF);
      misoQ.push_back(8'h00);
      misoQ.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
         p = 8'($urandom);
         misoQ.push_back(p);
         e.idx = 9'(i);
         e.data = p;
         expQ.push_back(e);
      end
      @(negedge clk);
      bus.blockAddr = $urandom;
      bus.isStart = 1'b1;
      base = strobeCnt;
      cyc = 0;
      while (strobeCnt < base + 101 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_strobe_100", 32'(strobeCnt - base), 32'(101));
      reset = 1'b1;
      bus.isStart = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkReset("mid_reset");
      reset = 1'b0;
      repeat (2000) @(negedge clk);
      check("no_strobe_after_reset", 32'(strobeCnt - base), 32'(101));
      check("idle_cs_after_reset", 32'(bus.CS), 32'(1));
      $display("reset mid-data after %0d strobes", strobeCnt - base);
   endtask

   initial begin
      int kind, r1d, tokd;
      logic [7:0] r1, tok;
      bus.isStart = 1'b0;
      bus.blockAddr = 32'h0;
      repeat (3) @(negedge clk);
      checkReset("por");
      reset = 1'b0;

      runRead(32'h0000_0010, 1, 8'h00, 0, 8'hFE, 1'b1, 50);
      runRead(32'h1234_5678, 0, 8'h05, 0, 8'hFE, 1'b0, 2);
      runRead(32'h0000_0001, 100, 8'hFF, 0, 8'hFE, 1'b1, 2);
      runRead(32'h0000_0002, 0, 8'h00, TOK_TO + 20, 8'hFF, 1'b1, 2);
      runRead(32'h0000_0003, 0, 8'h00, 0, 8'h08, 1'b1, 2);

      for (int n = 0; n < 5; n++) begin
         kind = $urandom_range(0, 3);
         r1d = $urandom_range(0, R1_TO - 1);
         r1 = 8'h00;
         tokd = $urandom_range(0, TOK_TO - 1);
         tok = 8'($urandom_range(0, 15));
         case (kind)
            0: r1d = $urandom_range(R1_TO, R1_TO + 4);
            1: r1 = 8'($urandom_range(1, 127));
            2: tokd = $urandom_range(TOK_TO, TOK_TO + 6);
            default: ;
         endcase
         runRead($urandom, r1d, r1, tokd, tok, 1'b0, $urandom_range(1, 5));
      end

      resetMidData();
      runRead($urandom, $urandom_range(0, R1_TO - 1), 8'h00, $urandom_range(0, 20), 8'hFE, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
